// File: rtl/ans_ht_ltf_rx.sv
// HT-LTF receive correlator: drops the cyclic prefix, buffers the 64-sample body and
// correlates it against the generator reference. Optional energy meter: ANS_HT_LTF_RX_ENERGY_EN.
module ans_ht_ltf_rx #(
    parameter int CP_LEN = 16,
    parameter int N_BODY = 64,
    parameter int ACC_W  = 40
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ltf_start,
    input  logic [31:0]               sample_in,
    input  logic                      sample_valid,
    output logic [$clog2(N_BODY)-1:0] ref_addr,
    input  logic [31:0]               ref_data,
    input  logic [ACC_W-1:0]          threshold,
    output logic                      ltf_busy,
    output logic                      ltf_done,
    output logic                      ltf_match,
    output logic signed [ACC_W-1:0]   corr_i,
    output logic signed [ACC_W-1:0]   corr_q,
    output logic [ACC_W-1:0]          ltf_energy
);
    localparam int IDX_W = $clog2(N_BODY);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SKIP_CP   = 3'd1;
    localparam logic [2:0] CAPTURE   = 3'd2;
    localparam logic [2:0] CORR      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [7:0] CP_LAST   = 8'(CP_LEN - 1);
    localparam logic [7:0] BODY_LAST = 8'(N_BODY - 1);
    // Last product lands two cycles after the last address; results register one cycle later.
    localparam logic [7:0] CORR_LAST = 8'(N_BODY + 2);

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        sext16 = $signed({{16{v[15]}}, v});
    endfunction

    function automatic logic [ACC_W:0] abs_ext(input logic [ACC_W-1:0] v);
        logic [ACC_W:0] x;
        x = {v[ACC_W-1], v};
        if (v[ACC_W-1]) begin
            abs_ext = ~x + (ACC_W+1)'(1);
        end else begin
            abs_ext = x;
        end
    endfunction

    logic [2:0]              state_r;
    logic [7:0]              cnt_r;
    logic [IDX_W-1:0]        ref_addr_r;
    logic                    busy_r, done_r, match_r;
    logic signed [ACC_W-1:0] corr_i_r, corr_q_r, acc_i_r, acc_q_r;
    logic                    rd_v_r, prod_v_r;
    logic [31:0]             rx_rd_r;
    logic signed [32:0]      term_re_r, term_im_r;
    logic [31:0]             body_mem_r [N_BODY];

    logic signed [31:0]      p_ii_s, p_qq_s, p_qi_s, p_iq_s;
    logic signed [32:0]      term_re_s, term_im_s;
    logic [ACC_W:0]          mag_s;
    logic                    match_s;

    // rx * conj(ref) for the sample pair currently on the read stage.
    always_comb begin
        p_ii_s    = sext16(rx_rd_r[31:16]) * sext16(ref_data[31:16]);
        p_qq_s    = sext16(rx_rd_r[15:0])  * sext16(ref_data[15:0]);
        p_qi_s    = sext16(rx_rd_r[15:0])  * sext16(ref_data[31:16]);
        p_iq_s    = sext16(rx_rd_r[31:16]) * sext16(ref_data[15:0]);
        term_re_s = {p_ii_s[31], p_ii_s} + {p_qq_s[31], p_qq_s};
        term_im_s = {p_qi_s[31], p_qi_s} - {p_iq_s[31], p_iq_s};
    end

    // L1 magnitude of the finished accumulators against the threshold.
    always_comb begin
        mag_s   = abs_ext(acc_i_r) + abs_ext(acc_q_r);
        match_s = (mag_s >= {1'b0, threshold});
    end

    // Body capture store; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (state_r == CAPTURE && sample_valid && !ltf_start) begin
            body_mem_r[cnt_r[IDX_W-1:0]] <= sample_in;
        end
    end

    // Control FSM, correlation pipeline and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            ref_addr_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            match_r    <= 1'b0;
            corr_i_r   <= '0;
            corr_q_r   <= '0;
            acc_i_r    <= '0;
            acc_q_r    <= '0;
            rd_v_r     <= 1'b0;
            prod_v_r   <= 1'b0;
            rx_rd_r    <= 32'd0;
            term_re_r  <= '0;
            term_im_r  <= '0;
        end else if (ltf_start) begin
            // A coincident valid sample is CP sample 0.
            state_r    <= SKIP_CP;
            cnt_r      <= sample_valid ? 8'd1 : 8'd0;
            ref_addr_r <= '0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            match_r    <= 1'b0;
            corr_i_r   <= '0;
            corr_q_r   <= '0;
            acc_i_r    <= '0;
            acc_q_r    <= '0;
            rd_v_r     <= 1'b0;
            prod_v_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                SKIP_CP: begin
                    if (sample_valid) begin
                        if (cnt_r == CP_LAST) begin
                            state_r <= CAPTURE;
                            cnt_r   <= 8'd0;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        if (cnt_r == BODY_LAST) begin
                            state_r    <= CORR;
                            cnt_r      <= 8'd0;
                            ref_addr_r <= '0;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                end
                CORR: begin
                    cnt_r     <= cnt_r + 8'd1;
                    rd_v_r    <= (cnt_r <= BODY_LAST);
                    rx_rd_r   <= body_mem_r[cnt_r[IDX_W-1:0]];
                    prod_v_r  <= rd_v_r;
                    term_re_r <= term_re_s;
                    term_im_r <= term_im_s;
                    if (cnt_r < BODY_LAST) begin
                        ref_addr_r <= ref_addr_r + IDX_W'(1);
                    end
                    if (prod_v_r) begin
                        acc_i_r <= acc_i_r + ACC_W'(term_re_r);
                        acc_q_r <= acc_q_r + ACC_W'(term_im_r);
                    end
                    if (cnt_r == CORR_LAST) begin
                        state_r  <= DONE;
                        done_r   <= 1'b1;
                        corr_i_r <= acc_i_r;
                        corr_q_r <= acc_q_r;
                        match_r  <= match_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ANS_HT_LTF_RX_ENERGY_EN
    logic signed [31:0] sq_i_s, sq_q_s;
    logic [32:0]        sq_sum_s;
    logic [ACC_W-1:0]   energy_acc_r, energy_r;

    // Per-sample power of the incoming body sample.
    always_comb begin
        sq_i_s   = sext16(sample_in[31:16]) * sext16(sample_in[31:16]);
        sq_q_s   = sext16(sample_in[15:0])  * sext16(sample_in[15:0]);
        sq_sum_s = {1'b0, sq_i_s} + {1'b0, sq_q_s};
    end

    // Body energy accumulator, published together with the correlation results.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            energy_acc_r <= '0;
            energy_r     <= '0;
        end else if (ltf_start) begin
            energy_acc_r <= '0;
            energy_r     <= '0;
        end else if (state_r == CAPTURE && sample_valid) begin
            energy_acc_r <= energy_acc_r + ACC_W'(sq_sum_s);
        end else if (state_r == CORR && cnt_r == CORR_LAST) begin
            energy_r <= energy_acc_r;
        end
    end

    assign ltf_energy = energy_r;
`else
    assign ltf_energy = '0;
`endif

    assign ref_addr  = ref_addr_r;
    assign ltf_busy  = busy_r;
    assign ltf_done  = done_r;
    assign ltf_match = match_r;
    assign corr_i    = corr_i_r;
    assign corr_q    = corr_q_r;
endmodule

// File: tb/tb_ans_ht_ltf_rx.sv
// Self-checking bench for ans_ht_ltf_rx: directed test-plan symbols plus randomized symbols
// checked against a plain-arithmetic correlation model.
module tb_ans_ht_ltf_rx;
    localparam int ACC_W = 40;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    ltf_start;
    logic [31:0]             sample_in;
    logic                    sample_valid;
    logic [5:0]              ref_addr;
    logic [31:0]             ref_data = 32'd0;
    logic [ACC_W-1:0]        threshold;
    logic                    ltf_busy, ltf_done, ltf_match;
    logic signed [ACC_W-1:0] corr_i, corr_q;
    logic [ACC_W-1:0]        ltf_energy;

    logic [31:0] rx_samp [80];
    logic [31:0] ref_mem [64];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_cyc = 0;

    ans_ht_ltf_rx dut (
        .clk(clk), .rstn(rstn), .ltf_start(ltf_start), .sample_in(sample_in),
        .sample_valid(sample_valid), .ref_addr(ref_addr), .ref_data(ref_data),
        .threshold(threshold), .ltf_busy(ltf_busy), .ltf_done(ltf_done),
        .ltf_match(ltf_match), .corr_i(corr_i), .corr_q(corr_q), .ltf_energy(ltf_energy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ltf_done) done_cnt <= done_cnt + 1;
    // Generator sample store: one-cycle read latency.
    always @(posedge clk) ref_data <= ref_mem[ref_addr];

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] cp_v, input logic [31:0] body_v, input logic [31:0] ref_v);
        for (int k = 0; k < 80; k++) rx_samp[k] = (k < 16) ? cp_v : body_v;
        for (int k = 0; k < 64; k++) ref_mem[k] = ref_v;
    endtask

    // Reference: sum over the body of rx*conj(ref), and body energy.
    task automatic model(output longint ei, output longint eq, output longint ee);
        longint ri, rq, fi, fq;
        ei = 0; eq = 0; ee = 0;
        for (int k = 0; k < 64; k++) begin
            ri = longint'($signed(rx_samp[16+k][31:16]));
            rq = longint'($signed(rx_samp[16+k][15:0]));
            fi = longint'($signed(ref_mem[k][31:16]));
            fq = longint'($signed(ref_mem[k][15:0]));
            ei += ri * fi + rq * fq;
            eq += rq * fi - ri * fq;
            ee += ri * ri + rq * rq;
        end
    endtask

    // gap_mode: 0 continuous, 1 alternating valid, 2 random gaps. junk keeps valid high afterwards.
    task automatic send_sym(input int gap_mode, input int stop_at, input bit junk);
        int i = 0;
        bit first = 1'b1;
        bit phase = 1'b0;
        while (i < stop_at) begin
            @(negedge clk);
            ltf_start = first;
            first = 1'b0;
            case (gap_mode)
                1:       sample_valid = ~phase;
                2:       sample_valid = ($urandom_range(0, 3) != 0);
                default: sample_valid = 1'b1;
            endcase
            phase = ~phase;
            if (sample_valid) begin
                sample_in = rx_samp[i];
                if (i == 79) acc_cyc = cyc + 1;
                i++;
            end else begin
                sample_in = $urandom;
            end
        end
        @(negedge clk);
        ltf_start    = 1'b0;
        sample_valid = junk;
        sample_in    = $urandom;
    endtask

    task automatic wait_done(input string tag, input longint ei, input longint eq, input longint ee);
        int t = 0;
        bit seen = 1'b0;
        bit busy_gap = 1'b0;
        longint mag, ee_exp;
        while (!seen && t < 400) begin
            @(negedge clk);
            t++;
            if (!ltf_busy) busy_gap = 1'b1;
            seen = ltf_done;
        end
        mag = (ei < 0 ? -ei : ei) + (eq < 0 ? -eq : eq);
`ifdef ANS_HT_LTF_RX_ENERGY_EN
        ee_exp = ee;
`else
        ee_exp = 0 * ee;
`endif
        chk({tag, "/done_seen"}, 64'(seen), 64'sd1);
        chk({tag, "/latency"}, 64'(cyc - acc_cyc), 64'sd67);
        chk({tag, "/busy_span"}, 64'(busy_gap), 64'sd0);
        chk({tag, "/corr_i"}, 64'(corr_i), ei);
        chk({tag, "/corr_q"}, 64'(corr_q), eq);
        chk({tag, "/match"}, 64'(ltf_match), (mag >= longint'(threshold)) ? 64'sd1 : 64'sd0);
        chk({tag, "/energy"}, 64'(ltf_energy), ee_exp);
        @(negedge clk);
        sample_valid = 1'b0;
        chk({tag, "/done_pulse"}, 64'(ltf_done), 64'sd0);
        chk({tag, "/busy_fall"}, 64'(ltf_busy), 64'sd0);
        chk({tag, "/corr_i_hold"}, 64'(corr_i), ei);
    endtask

    initial begin
        longint ei, eq, ee, mag;
        int d0;
        rstn = 1'b0; ltf_start = 1'b0; sample_valid = 1'b0; sample_in = 32'd0;
        threshold = 40'd0;
        fill(32'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst/busy", 64'(ltf_busy), 64'sd0);
        chk("rst/done", 64'(ltf_done), 64'sd0);
        chk("rst/match", 64'(ltf_match), 64'sd0);
        chk("rst/corr_i", 64'(corr_i), 64'sd0);
        chk("rst/corr_q", 64'(corr_q), 64'sd0);
        chk("rst/energy", 64'(ltf_energy), 64'sd0);
        chk("rst/ref_addr", 64'(ref_addr), 64'sd0);
        rstn = 1'b1;
        @(negedge clk);

        fill(32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
        threshold = 40'd4194304;
        send_sym(0, 80, 1'b0);
        wait_done("matched", 64'sd4194304, 64'sd0, 64'sd4194304);
        threshold = 40'd4194305;
        send_sym(0, 80, 1'b1);
        wait_done("matched_thr", 64'sd4194304, 64'sd0, 64'sd4194304);

        threshold = 40'd4194304;
        fill(32'h0000_0100, 32'h0000_0100, 32'h0100_0000);
        send_sym(0, 80, 1'b0);
        wait_done("conj", 64'sd0, 64'sd4194304, 64'sd4194304);
        fill(32'h0100_0000, 32'h0100_0000, 32'h0000_0100);
        send_sym(0, 80, 1'b0);
        wait_done("conj_swap", 64'sd0, -64'sd4194304, 64'sd4194304);

        fill(32'h7FFF_7FFF, 32'h0100_0000, 32'h0100_0000);
        send_sym(0, 80, 1'b1);
        wait_done("cp_discard", 64'sd4194304, 64'sd0, 64'sd4194304);

        fill(32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
        send_sym(1, 80, 1'b0);
        wait_done("valid_gaps", 64'sd4194304, 64'sd0, 64'sd4194304);

        for (int k = 0; k < 80; k++) rx_samp[k] = $urandom;
        d0 = done_cnt;
        send_sym(0, 46, 1'b0);
        fill(32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
        send_sym(0, 80, 1'b0);
        wait_done("restart", 64'sd4194304, 64'sd0, 64'sd4194304);
        repeat (5) @(negedge clk);
        chk("restart/single_done", 64'(done_cnt - d0), 64'sd1);

        send_sym(0, 80, 1'b0);
        repeat (19) @(negedge clk);
        rstn = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("midrst/busy", 64'(ltf_busy), 64'sd0);
        chk("midrst/done", 64'(ltf_done), 64'sd0);
        chk("midrst/match", 64'(ltf_match), 64'sd0);
        chk("midrst/corr_i", 64'(corr_i), 64'sd0);
        chk("midrst/corr_q", 64'(corr_q), 64'sd0);
        chk("midrst/energy", 64'(ltf_energy), 64'sd0);
        chk("midrst/ref_addr", 64'(ref_addr), 64'sd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (100) @(negedge clk);
        chk("midrst/no_done", 64'(done_cnt - d0), 64'sd0);
        fill(32'h0000_0100, 32'h0000_0100, 32'h0100_0000);
        send_sym(0, 80, 1'b0);
        wait_done("after_rst", 64'sd0, 64'sd4194304, 64'sd4194304);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 80; k++) rx_samp[k] = $urandom;
            for (int k = 0; k < 64; k++) ref_mem[k] = $urandom;
            model(ei, eq, ee);
            mag = (ei < 0 ? -ei : ei) + (eq < 0 ? -eq : eq);
            threshold = ACC_W'(mag - 1 + longint'(r % 3));
            send_sym(r % 3, 80, r[0]);
            wait_done($sformatf("rand%0d", r), ei, eq, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
